motor_cmd_sequencer: RTL and testbench

Parametrised robot drive command generator with an integrated 8N1 UART transmitter. It converts the navigation state (`direction`) and speed level (`speed`) into Create-style Drive Direct serial frames. A frame is sent whenever the commanded motion changes and again at a fixed refresh interval. It replaces the separate per-direction sequence generators and adds turning, speed scaling with clamping, change detection and keep-alive resend, with a single serial output.

---
 rtl/motor_cmd_sequencer.sv | 93 +++++++++
 tb/tb_motor_cmd_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer: turns direction/speed into Drive Direct frames sent over an 8N1 UART
module motor_cmd_sequencer #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int SPEED_W        = 3,
  parameter int VEL_STEP       = 50,
  parameter int MAX_VEL        = 500,
  parameter int REFRESH_CYCLES = 5_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         direction,
  input  logic [SPEED_W-1:0] speed,
  output logic               uart_out,
  output logic               busy,
  output logic               frame_done,
  output logic [2:0]         active_dir
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int PW = SPEED_W + 32;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] clk_cnt;
  logic [2:0] bit_idx, byte_idx, snap_dir;
  logic [SPEED_W-1:0] snap_spd;
  logic init_pend, tick, trig, last_byte;
  logic [31:0] refresh_cnt;
  logic [PW-1:0] prod;
  logic [15:0] vel, r_vel, l_vel;
  logic [7:0] cur_byte;
  assign tick = clk_cnt == CW'(CLKS_PER_BIT - 1);
  assign last_byte = byte_idx == 3'd6;
  assign trig = init_pend || {direction, speed} != {snap_dir, snap_spd} ||
                (REFRESH_CYCLES != 0 && refresh_cnt >= 32'(REFRESH_CYCLES));
  assign prod = {32'd0, snap_spd} * PW'(VEL_STEP);
  assign vel = prod > PW'(MAX_VEL) ? 16'(MAX_VEL) : prod[15:0];
  // Frame content derives from the snapshot, which is frozen for the whole frame
  always_comb begin
    r_vel = (snap_dir == 3'b001 || snap_dir == 3'b010) ? vel :
            (snap_dir == 3'b011 || snap_dir == 3'b100) ? -vel : 16'd0;
    l_vel = (snap_dir == 3'b001 || snap_dir == 3'b100) ? vel :
            (snap_dir == 3'b011 || snap_dir == 3'b010) ? -vel : 16'd0;
    case (byte_idx)
      3'd0:    cur_byte = 8'h80;
      3'd1:    cur_byte = 8'h83;
      3'd2:    cur_byte = 8'h91;
      3'd3:    cur_byte = r_vel[15:8];
      3'd4:    cur_byte = r_vel[7:0];
      3'd5:    cur_byte = l_vel[15:8];
      default: cur_byte = l_vel[7:0];
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    case (state)
      IDLE:    state_nx = trig ? START : IDLE;
      START:   state_nx = tick ? DATA : START;
      DATA:    state_nx = (tick && bit_idx == 3'd7) ? STOP : DATA;
      default: state_nx = tick ? (last_byte ? IDLE : START) : STOP;
    endcase
  end
  always_comb begin
    uart_out = state == START ? 1'b0 : state == DATA ? cur_byte[bit_idx] : 1'b1;
    busy = state != IDLE;
  end
  // Refresh count restarts at 1 on a frame start so the resend period is start-to-start
  always_ff @(posedge clk)
    if (rst) begin
      clk_cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      snap_dir <= '0;
      snap_spd <= '0;
      init_pend <= 1'b1;
      refresh_cnt <= '0;
      frame_done <= 1'b0;
      active_dir <= '0;
    end else begin
      frame_done <= state == STOP && tick && last_byte;
      clk_cnt <= (state == IDLE || tick) ? '0 : clk_cnt + CW'(1);
      refresh_cnt <= (state == IDLE && trig) ? 32'd1 : &refresh_cnt ? refresh_cnt : refresh_cnt + 32'd1;
      if (state == IDLE && trig) begin
        snap_dir <= direction;
        snap_spd <= speed;
        active_dir <= direction;
        init_pend <= 1'b0;
        byte_idx <= init_pend ? 3'd0 : 3'd2;
      end
      if (state == DATA && tick) bit_idx <= bit_idx + 3'd1;
      if (state == STOP && tick) byte_idx <= byte_idx + 3'd1;
    end
endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// tb_motor_cmd_sequencer: directed vectors on two instances (step 50/refresh 2000, step 100/no refresh)
module tb_motor_cmd_sequencer;
  localparam int CPB = 4;
  logic clk, rst;
  logic [2:0] direction, speed;
  logic uart_a, busy_a, frame_done_a, uart_b, busy_b, frame_done_b;
  logic [2:0] active_dir_a, active_dir_b;
  int checks = 0, errors = 0;
  motor_cmd_sequencer #(.CLKS_PER_BIT(CPB), .SPEED_W(3), .VEL_STEP(50), .MAX_VEL(500),
    .REFRESH_CYCLES(2000)) dut_a (.clk(clk), .rst(rst), .direction(direction), .speed(speed),
    .uart_out(uart_a), .busy(busy_a), .frame_done(frame_done_a), .active_dir(active_dir_a));
  motor_cmd_sequencer #(.CLKS_PER_BIT(CPB), .SPEED_W(3), .VEL_STEP(100), .MAX_VEL(500),
    .REFRESH_CYCLES(0)) dut_b (.clk(clk), .rst(rst), .direction(direction), .speed(speed),
    .uart_out(uart_b), .busy(busy_b), .frame_done(frame_done_b), .active_dir(active_dir_b));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // UART receivers: start detected at first low negedge, bits sampled mid-bit
  logic [1:0] line;
  assign line = {uart_b, uart_a};
  logic [7:0] q0[$], q1[$];
  bit act[2];
  int cnt[2];
  logic [7:0] sh[2];
  int framing_err = 0;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) act[k] = 1'b0;
      else if (!act[k]) begin
        act[k] = !line[k];
        cnt[k] = 0;
      end else begin
        cnt[k]++;
        if (cnt[k] >= 6 && cnt[k] <= 34 && (cnt[k] - 6) % CPB == 0) sh[k] = {line[k], sh[k][7:1]};
        if (cnt[k] == 38) begin
          act[k] = 1'b0;
          if (!line[k]) framing_err++;
          if (k == 0) q0.push_back(sh[k]);
          else q1.push_back(sh[k]);
        end
      end
    end
    if (rst) begin
      q0.delete();
      q1.delete();
    end
  end
  int cyc = 0, starts_a = 0, starts_b = 0, last_a = 0, fd_a = 0;
  logic pa = 1'b0, pb = 1'b0;
  always @(posedge clk) begin
    cyc++;
    if (busy_a && !pa) begin
      starts_a++;
      last_a = cyc;
    end
    if (busy_b && !pb) starts_b++;
    if (frame_done_a) fd_a++;
    pa = busy_a;
    pb = busy_b;
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic logic [31:0] pop(input bit b);
    if (b) return q1.size() != 0 ? {24'd0, q1.pop_front()} : 32'hDEAD;
    return q0.size() != 0 ? {24'd0, q0.pop_front()} : 32'hDEAD;
  endfunction
  task automatic chk_frame(input string nm, input bit init, input logic [15:0] r, input logic [15:0] l, input bit b);
    logic [7:0] e[$];
    if (init) begin
      e.push_back(8'h80);
      e.push_back(8'h83);
    end
    e.push_back(8'h91);
    e.push_back(r[15:8]);
    e.push_back(r[7:0]);
    e.push_back(l[15:8]);
    e.push_back(l[7:0]);
    chk($sformatf("%s_len", nm), b ? q1.size() : q0.size(), e.size());
    foreach (e[i]) chk($sformatf("%s_byte%0d", nm, i), pop(b), {24'd0, e[i]});
    if (b) q1.delete();
    else q0.delete();
  endtask
  task automatic wait_done(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done_a && n < 600);
    chk({nm, "_done"}, {31'd0, frame_done_a}, 1);
  endtask
  typedef struct {
    logic [2:0] dir, spd;
    logic [15:0] ra, la, rb, lb;
  } vec_t;
  vec_t tbl[8];
  initial begin
    int n, na0, nb0, sa0;
    tbl[0] = '{3'b001, 3'd3, 16'h0096, 16'h0096, 16'h012C, 16'h012C};
    tbl[1] = '{3'b011, 3'd2, 16'hFF9C, 16'hFF9C, 16'hFF38, 16'hFF38};
    tbl[2] = '{3'b010, 3'd7, 16'h015E, 16'hFEA2, 16'h01F4, 16'hFE0C};
    tbl[3] = '{3'b111, 3'd7, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[4] = '{3'b100, 3'd5, 16'hFF06, 16'h00FA, 16'hFE0C, 16'h01F4};
    tbl[5] = '{3'b001, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[6] = '{3'b100, 3'd1, 16'hFFCE, 16'h0032, 16'hFF9C, 16'h0064};
    tbl[7] = '{3'b000, 3'd6, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    rst = 1'b1;
    direction = 3'b000;
    speed = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_uart", {31'd0, uart_a}, 1);
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_frame_done", {31'd0, frame_done_a}, 0);
    chk("rst_active_dir", {29'd0, active_dir_a}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("init_start_uart", {31'd0, uart_a}, 0);
    chk("init_start_busy", {31'd0, busy_a}, 1);
    n = 0;
    while (busy_a && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("init_busy_cycles", n, 280);
    chk("init_frame_done", {31'd0, frame_done_a}, 1);
    chk_frame("init_a", 1'b1, 16'h0, 16'h0, 1'b0);
    chk_frame("init_b", 1'b1, 16'h0, 16'h0, 1'b1);
    @(negedge clk);
    chk("init_done_width", {31'd0, frame_done_a}, 0);
    chk("init_done_count", fd_a, 1);
    for (int i = 0; i < 8; i++) begin
      direction = tbl[i].dir;
      speed = tbl[i].spd;
      wait_done($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_active_dir", i), {29'd0, active_dir_a}, {29'd0, tbl[i].dir});
      chk_frame($sformatf("vec%0d_a", i), 1'b0, tbl[i].ra, tbl[i].la, 1'b0);
      chk_frame($sformatf("vec%0d_b", i), 1'b0, tbl[i].rb, tbl[i].lb, 1'b1);
    end
    direction = 3'b001;
    speed = 3'd2;
    repeat (30) @(negedge clk);
    direction = 3'b010;
    speed = 3'd4;
    repeat (30) @(negedge clk);
    direction = 3'b100;
    speed = 3'd3;
    wait_done("mid1");
    chk_frame("mid1_a", 1'b0, 16'h0064, 16'h0064, 1'b0);
    chk_frame("mid1_b", 1'b0, 16'h00C8, 16'h00C8, 1'b1);
    @(negedge clk);
    chk("mid_gap_busy", {31'd0, busy_a}, 1);
    chk("mid_gap_uart", {31'd0, uart_a}, 0);
    wait_done("mid2");
    chk_frame("mid2_a", 1'b0, 16'hFF6A, 16'h0096, 1'b0);
    chk_frame("mid2_b", 1'b0, 16'hFED4, 16'h012C, 1'b1);
    chk("mid2_active_dir", {29'd0, active_dir_a}, 3'b100);
    na0 = starts_a;
    nb0 = starts_b;
    sa0 = last_a;
    repeat (300) @(negedge clk);
    chk("mid_single_followup", starts_a, na0);
    n = 0;
    while (starts_a == na0 && n < 2500) begin
      n++;
      @(negedge clk);
    end
    chk("refresh_seen", starts_a, na0 + 1);
    chk("refresh_period", last_a - sa0, 2000);
    wait_done("refresh");
    chk_frame("refresh_a", 1'b0, 16'hFF6A, 16'h0096, 1'b0);
    chk("no_refresh_b_starts", starts_b, nb0);
    chk("no_refresh_b_bytes", q1.size(), 0);
    direction = 3'b001;
    speed = 3'd1;
    repeat (14) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy_a}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_uart", {31'd0, uart_a}, 1);
    chk("midrst_busy_a", {31'd0, busy_a}, 0);
    chk("midrst_busy_b", {31'd0, busy_b}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_done("reinit");
    chk_frame("reinit_a", 1'b1, 16'h0032, 16'h0032, 1'b0);
    chk_frame("reinit_b", 1'b1, 16'h0064, 16'h0064, 1'b1);
    chk("stop_bits", framing_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
